// File: rtl/dcache_controller.sv
// Write-back, write-allocate controller for a 16-set, 2-way data cache.
// Hits complete in the same cycle; misses stall while the victim is written back and the line refilled.
module dcache_controller #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  output logic [3:0]        sram_index_o,
  output logic [24:0]       sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  input  logic              sram_hit_i,
  input  logic [24:0]       sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [15:0]       miss_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       miss_cnt_q, miss_cnt_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;

  logic [22:0]       req_tag;
  logic [3:0]        index;
  logic [7:0]        bit_off;
  logic [ADDR_W-1:0] fetch_addr;
  logic [LINE_W-1:0] merged_line;
  logic              sram_write;
  logic              unused_addr_bits;

  assign req_tag          = cpu_addr_i[31:9];
  assign index            = cpu_addr_i[8:5];
  assign bit_off          = {cpu_addr_i[4:2], 5'b00000};
  assign fetch_addr       = {cpu_addr_i[31:5], 5'b00000};
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign sram_enable_o = cpu_req_i;
  assign sram_index_o  = index;
  assign cpu_data_o    = sram_data_i[bit_off +: WORD_W];

  // Reset suppresses the strobe so an aborted transaction never touches the SRAM.
  assign sram_write_o  = sram_write & ~rst_i;

  assign mem_enable_o  = mem_enable_q;
  assign mem_write_o   = mem_write_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_o    = mem_data_q;
  assign miss_cnt_o    = miss_cnt_q;

  always_comb begin
    merged_line                    = sram_data_i;
    merged_line[bit_off +: WORD_W] = cpu_data_i;
  end

  always_comb begin
    state_d      = state_q;
    miss_cnt_d   = miss_cnt_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    cpu_stall_o  = 1'b1;
    sram_write   = 1'b0;
    sram_tag_o   = {2'b10, req_tag};
    sram_data_o  = mem_data_i;

    case (state_q)
      IDLE: begin
        cpu_stall_o = 1'b0;
        if (cpu_req_i) begin
          if (sram_hit_i) begin
            if (cpu_wr_i) begin
              sram_write  = 1'b1;
              sram_tag_o  = {2'b11, req_tag};
              sram_data_o = merged_line;
            end
          end else begin
            cpu_stall_o = 1'b1;
            state_d     = MISS;
            miss_cnt_d  = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
          end
        end
      end

      // The SRAM presents the LRU victim here because the access missed.
      MISS: begin
        mem_enable_d = 1'b1;
        if (sram_tag_i[24] && sram_tag_i[23]) begin
          mem_write_d = 1'b1;
          mem_addr_d  = {sram_tag_i[22:0], index, 5'b00000};
          mem_data_d  = sram_data_i;
          state_d     = WRITEBACK;
        end else begin
          mem_write_d = 1'b0;
          mem_addr_d  = fetch_addr;
          state_d     = READMISS;
        end
      end

      WRITEBACK: begin
        if (mem_ack_i) begin
          mem_write_d = 1'b0;
          mem_addr_d  = fetch_addr;
          state_d     = READMISS;
        end
      end

      READMISS: begin
        if (mem_ack_i) begin
          mem_enable_d = 1'b0;
          sram_write   = 1'b1;
          sram_tag_o   = {2'b10, req_tag};
          sram_data_o  = mem_data_i;
          state_d      = READMISSOK;
        end
      end

      READMISSOK: begin
        state_d = IDLE;
      end

      default: begin
        state_d      = IDLE;
        mem_enable_d = 1'b0;
        mem_write_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      miss_cnt_q   <= 16'd0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      miss_cnt_q   <= miss_cnt_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

endmodule
